// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stopwatch_pkg
// Purpose : Shared types and constants for the stopwatch time-keeping stage:
//           FSM state encoding, BCD digit width, field limits and the
//           per-field blank masks used by the display multiplexer.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      PAUSE = 1'b1
   } sw_state_t;

   localparam int DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] FIELD_MAX_TENS = 4'd5;
   localparam logic [DIGIT_W-1:0] FIELD_MAX_ONES = 4'd9;

   // Blank mask bit order is {min_tens, min_ones, sec_tens, sec_ones}
   localparam logic [3:0] BLANK_MIN  = 4'b1100;
   localparam logic [3:0] BLANK_SEC  = 4'b0011;
   localparam logic [3:0] BLANK_NONE = 4'b0000;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/mod60_bcd.sv
`default_nettype none
// ============================================================================
// Module  : mod60_bcd
// Purpose : Two-digit BCD field counting 00..59 and wrapping to 00.
// Ports   : clk       - system clock
//           rst       - asynchronous active-high reset, clears both digits
//           inc       - advance the field by one on this clock edge
//           tens      - BCD tens digit (0..5)
//           ones      - BCD ones digit (0..9)
//           carry_out - combinational, high when inc is asserted at 59
// Revision: 1.0 - initial release
// ============================================================================
module mod60_bcd
   import stopwatch_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               inc,
   output logic [DIGIT_W-1:0] tens,
   output logic [DIGIT_W-1:0] ones,
   output logic               carry_out
);

   logic w_ones_max;
   logic w_tens_max;

   assign w_ones_max = (ones == FIELD_MAX_ONES);
   assign w_tens_max = (tens == FIELD_MAX_TENS);
   assign carry_out  = inc & w_ones_max & w_tens_max;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tens <= '0;
         ones <= '0;
      end else if (inc) begin
         if (w_ones_max) begin
            ones <= '0;
            tens <= w_tens_max ? '0 : tens + 4'd1;
         end else begin
            ones <= ones + 4'd1;
         end
      end
   end

endmodule : mod60_bcd
`default_nettype wire

// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module  : stopwatch_counter
// Purpose : MM:SS stopwatch. Edge-detects the divider's 1 Hz count clock and
//           2 Hz adjust clock, runs a RUN/PAUSE FSM, supports per-field
//           manual adjust and produces a per-digit blink mask.
// Config  : STOPWATCH_BLINK_EN - when defined, blank flashes the selected
//           field in adjust mode; when undefined blank is tied to zero and
//           blink_clk is ignored.
// Ports   : clk          - system clock
//           rst          - asynchronous active-high reset
//           counter_clk  - 1 Hz level, rising edge = count tick
//           adj_clk      - 2 Hz level, rising edge = adjust tick
//           blink_clk    - blink level
//           pause_pulse  - one-cycle RUN/PAUSE toggle request
//           adj          - adjust mode switch
//           sel          - adjust field: 0 minutes, 1 seconds
//           min_tens..sec_ones - BCD digits
//           running      - registered: RUN and not adjusting
//           blank        - registered per-digit blank mask
// Revision: 1.0 - initial release
// ============================================================================
module stopwatch_counter
   import stopwatch_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               counter_clk,
   input  logic               adj_clk,
   input  logic               blink_clk,
   input  logic               pause_pulse,
   input  logic               adj,
   input  logic               sel,
   output logic [DIGIT_W-1:0] min_tens,
   output logic [DIGIT_W-1:0] min_ones,
   output logic [DIGIT_W-1:0] sec_tens,
   output logic [DIGIT_W-1:0] sec_ones,
   output logic               running,
   output logic [3:0]         blank
);

   sw_state_t r_state;
   sw_state_t w_state_next;

   logic r_cnt_prev;
   logic r_adj_prev;
   logic w_cnt_tick;
   logic w_adj_tick;
   logic w_sec_inc;
   logic w_min_inc;
   logic w_sec_carry;
   logic w_min_carry_unused;
   logic w_running_next;

   // Previous-value registers power up high, like the divider outputs, so
   // a divider that is already high at reset release never fakes a tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt_prev <= 1'b1;
         r_adj_prev <= 1'b1;
      end else begin
         r_cnt_prev <= counter_clk;
         r_adj_prev <= adj_clk;
      end
   end

   assign w_cnt_tick = counter_clk & ~r_cnt_prev;
   assign w_adj_tick = adj_clk & ~r_adj_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RUN;
         running <= 1'b1;
      end else begin
         r_state <= w_state_next;
         running <= w_running_next;
      end
   end

   // The count decision uses the pre-toggle state, so a tick coinciding
   // with a pause request is counted only when leaving RUN.
   always_comb begin
      w_state_next   = r_state;
      w_sec_inc      = 1'b0;
      w_min_inc      = 1'b0;
      w_running_next = 1'b0;

      if (adj) begin
         // Adjust mode: count ticks are dropped and fields never carry.
         w_sec_inc = w_adj_tick & sel;
         w_min_inc = w_adj_tick & ~sel;
      end else begin
         if (r_state == RUN) begin
            w_sec_inc = w_cnt_tick;
            w_min_inc = w_sec_carry;
         end
         if (pause_pulse) begin
            w_state_next = (r_state == RUN) ? PAUSE : RUN;
         end
      end

      w_running_next = (w_state_next == RUN) & ~adj;
   end

   mod60_bcd u_sec (
      .clk       (clk),
      .rst       (rst),
      .inc       (w_sec_inc),
      .tens      (sec_tens),
      .ones      (sec_ones),
      .carry_out (w_sec_carry)
   );

   mod60_bcd u_min (
      .clk       (clk),
      .rst       (rst),
      .inc       (w_min_inc),
      .tens      (min_tens),
      .ones      (min_ones),
      .carry_out (w_min_carry_unused)
   );

`ifdef STOPWATCH_BLINK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blank <= BLANK_NONE;
      end else if (adj && blink_clk) begin
         blank <= sel ? BLANK_SEC : BLANK_MIN;
      end else begin
         blank <= BLANK_NONE;
      end
   end
`else
   logic w_unused_blink;
   assign w_unused_blink = blink_clk;
   assign blank          = BLANK_NONE;
`endif

endmodule : stopwatch_counter
`default_nettype wire
